// File: rtl/add_scheduler.sv
// add_scheduler: shares one NIB_W-bit carry-lookahead adder between two
// requesters. Each DATA_W-bit add runs as a chain of NIB_W-bit passes,
// starting with the low nibble. The carry is rippled from one pass to the next.
// Build option: define ARB_RR_EN for round-robin arbitration. Without it,
// arbitration is fixed priority and req0 wins every simultaneous request.
module add_scheduler #(
    parameter int DATA_W  = 8,
    parameter int NIB_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic              cin0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic              cin1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] res,
    output logic              cout,
    output logic              err,
    output logic              busy,
    output logic              add_en,
    output logic              add_c_in,
    output logic [NIB_W-1:0]  add_A,
    output logic [NIB_W-1:0]  add_B,
    input  logic              add_ready,
    input  logic [NIB_W-1:0]  add_out,
    input  logic              add_cout
);

    localparam int NUM_NIB = DATA_W / NIB_W;
    localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        GAP   = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_t;

    state_t            state;
    logic              id;        // requester that owns the current operation
    logic [DATA_W-1:0] a_lat;
    logic [DATA_W-1:0] b_lat;
    logic [DATA_W-1:0] sum;       // result nibbles collected so far
    logic              carry;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_inc;
    logic [CNT_W-1:0]  cnt;       // ISSUE cycles spent waiting for add_ready
    logic              grant1;
    logic [DATA_W-1:0] win_a;
    logic [DATA_W-1:0] win_b;
    logic              win_cin;
`ifdef ARB_RR_EN
    logic              last_id;
`endif

    // Pick the winning requester from the requests currently pending
    always_comb begin
`ifdef ARB_RR_EN
        grant1 = req1 && (!req0 || !last_id);
`else
        grant1 = req1 && !req0;
`endif
    end

    assign win_a   = grant1 ? a1 : a0;
    assign win_b   = grant1 ? b1 : b0;
    assign win_cin = grant1 ? cin1 : cin0;
    assign idx_inc = idx + 1'b1;
    assign busy    = (state != IDLE);

    // Sequencer: every output below is loaded on the edge that enters its state
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking (<=) so every read in this block sees pre-edge values.
        if (reset) begin
            state    <= IDLE;
            id       <= 1'b0;
            a_lat    <= '0;
            b_lat    <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            res      <= '0;
            cout     <= 1'b0;
            err      <= 1'b0;
            add_en   <= 1'b0;
            add_c_in <= 1'b0;
            add_A    <= '0;
            add_B    <= '0;
`ifdef ARB_RR_EN
            last_id  <= 1'b1;   // makes requester 0 win the first tie
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        id       <= grant1;
                        a_lat    <= win_a;
                        b_lat    <= win_b;
                        idx      <= '0;
                        cnt      <= '0;
                        add_en   <= 1'b1;
                        add_A    <= win_a[NIB_W-1:0];
                        add_B    <= win_b[NIB_W-1:0];
                        add_c_in <= win_cin;
                        state    <= ISSUE;
`ifdef ARB_RR_EN
                        last_id  <= grant1;
`endif
                    end
                end
                ISSUE: begin
                    if (add_ready) begin
                        sum[int'(idx) * NIB_W +: NIB_W] <= add_out;
                        carry  <= add_cout;
                        add_en <= 1'b0;
                        cnt    <= '0;
                        state  <= GAP;
                    end else if (cnt == CNT_LAST) begin
                        // The adder never answered: discard the partial sum and report the error
                        add_en <= 1'b0;
                        res    <= '0;
                        cout   <= 1'b0;
                        err    <= 1'b1;
                        done0  <= !id;
                        done1  <= id;
                        state  <= ABORT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (idx == LAST_IDX) begin
                        res   <= sum;
                        cout  <= carry;
                        err   <= 1'b0;
                        done0 <= !id;
                        done1 <= id;
                        state <= DONE;
                    end else begin
                        idx      <= idx_inc;
                        add_en   <= 1'b1;
                        add_A    <= a_lat[int'(idx_inc) * NIB_W +: NIB_W];
                        add_B    <= b_lat[int'(idx_inc) * NIB_W +: NIB_W];
                        add_c_in <= carry;
                        state    <= ISSUE;
                    end
                end
                DONE, ABORT: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_scheduler.sv
// tb_add_scheduler: self-checking bench for add_scheduler. A behavioural
// adder with programmable en->ready latency sits on the adder port. Results
// are predicted from whole-word arithmetic, the latency formula and an
// arbitration order model. Define ARB_RR_EN here and in the RTL together.
module tb_add_scheduler;

    localparam int DATA_W  = 8;
    localparam int NIB_W   = 4;
    localparam int TIMEOUT = 15;
    localparam int N       = DATA_W / NIB_W;
    localparam int BUDGET  = 300;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic [DATA_W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic              cin0 = 1'b0, cin1 = 1'b0;
    logic              done0, done1, cout, err, busy;
    logic [DATA_W-1:0] res;
    logic              add_en, add_c_in, add_ready, add_cout;
    logic [NIB_W-1:0]  add_A, add_B, add_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural adder: ready after lat cycles of en, or never when stalled
    int lat    = 1;
    bit stall  = 1'b0;
    int en_cnt = 0;
    logic [NIB_W:0] nsum;

    assign nsum      = add_A + add_B + add_c_in;
    assign add_out   = nsum[NIB_W-1:0];
    assign add_cout  = nsum[NIB_W];
    assign add_ready = add_en && !stall && (en_cnt == lat - 1);

    always @(posedge clk) begin
        if (!add_en || add_ready) en_cnt <= 0;
        else                      en_cnt <= en_cnt + 1;
    end

    always #5 clk = ~clk;

    add_scheduler #(.DATA_W(DATA_W), .NIB_W(NIB_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
        .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
        .done0(done0), .done1(done1), .res(res), .cout(cout), .err(err), .busy(busy),
        .add_en(add_en), .add_c_in(add_c_in), .add_A(add_A), .add_B(add_B),
        .add_ready(add_ready), .add_out(add_out), .add_cout(add_cout)
    );

    task automatic do_reset();
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0; stall = 1'b0; reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({busy, done0, done1, cout, err, add_en, add_c_in} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {busy, done0, done1, cout, err, add_en, add_c_in});
        end
        n_checks++;
        if (res !== '0) begin
            n_fail++;
            $display("FAIL reset_res: got %h expected 00", res);
        end
        n_checks++;
        if ({add_A, add_B} !== '0) begin
            n_fail++;
            $display("FAIL reset_operands: got %h expected 00", {add_A, add_B});
        end
    endtask

    // One operation from one requester, checked against whole-word arithmetic
    task automatic run_op(input bit rid, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input bit cin, input int l);
        int cyc, en_cycles, low_run, exp_sum;
        bit got, seen_high, gap_bad;
        logic [NIB_W-1:0] hs_a[$], hs_b[$];
        logic hs_c[$];
        lat = l; stall = 1'b0;
        @(negedge clk);
        if (rid == 1'b0) begin a0 = a; b0 = b; cin0 = cin; req0 = 1'b1; end
        else             begin a1 = a; b1 = b; cin1 = cin; req1 = 1'b1; end
        cyc = 1; got = 1'b0; en_cycles = 0; low_run = 0; seen_high = 1'b0; gap_bad = 1'b0;
        while (!got && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                // Scramble operands after grant; the latched copy must be used
                if (rid == 1'b0) begin a0 = DATA_W'($urandom); b0 = DATA_W'($urandom); end
                else             begin a1 = DATA_W'($urandom); b1 = DATA_W'($urandom); end
            end
            if (add_en && add_ready) begin
                hs_a.push_back(add_A); hs_b.push_back(add_B); hs_c.push_back(add_c_in);
            end
            if (add_en) begin
                if (seen_high && low_run != 0 && low_run != 1) gap_bad = 1'b1;
                seen_high = 1'b1; low_run = 0; en_cycles++;
            end else if (seen_high) begin
                low_run++;
            end
            if (done0 || done1) got = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL op_timeout: got no done after %0d cycles, required done", cyc);
            do_reset();
            return;
        end
        exp_sum = int'(a) + int'(b) + int'(cin);
        n_checks++;
        if ({done1, done0} !== (rid ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL op_done_id: got done1/done0=%b%b expected requester %0d", done1, done0, rid);
        end
        n_checks++;
        if (res !== DATA_W'(exp_sum)) begin
            n_fail++;
            $display("FAIL op_res: %h+%h+%0d got %h expected %h", a, b, cin, res, DATA_W'(exp_sum));
        end
        n_checks++;
        if (cout !== 1'((exp_sum >> DATA_W) & 1)) begin
            n_fail++;
            $display("FAIL op_cout: %h+%h+%0d got %b expected %0d", a, b, cin, cout, (exp_sum >> DATA_W) & 1);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL op_err: got %b expected 0", err);
        end
        n_checks++;
        if (cyc != 1 + N * (l + 1) + 1) begin
            n_fail++;
            $display("FAIL op_latency: L=%0d got %0d cycles expected %0d", l, cyc, 1 + N * (l + 1) + 1);
        end
        n_checks++;
        if (en_cycles != N * l || gap_bad) begin
            n_fail++;
            $display("FAIL op_en_shape: got %0d en cycles gap_bad=%0d expected %0d with 1-cycle gaps", en_cycles, gap_bad, N * l);
        end
        n_checks++;
        if (hs_c.size() != N) begin
            n_fail++;
            $display("FAIL op_passes: got %0d adder passes expected %0d", hs_c.size(), N);
        end else begin
            for (int k = 0; k < N; k++) begin
                int m, exp_c, exp_a, exp_b;
                m     = 1 << (k * NIB_W);
                exp_c = ((int'(a) % m) + (int'(b) % m) + int'(cin)) / m;
                exp_a = (int'(a) / m) % (1 << NIB_W);
                exp_b = (int'(b) / m) % (1 << NIB_W);
                n_checks++;
                if (hs_a[k] !== NIB_W'(exp_a) || hs_b[k] !== NIB_W'(exp_b) || hs_c[k] !== 1'(exp_c)) begin
                    n_fail++;
                    $display("FAIL op_pass%0d: got A=%h B=%h cin=%b expected A=%h B=%h cin=%0d",
                             k, hs_a[k], hs_b[k], hs_c[k], NIB_W'(exp_a), NIB_W'(exp_b), exp_c);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if ({done0, done1, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL op_single_pulse: got done0/done1/busy=%b%b%b expected 000", done0, done1, busy);
        end
    endtask

    task automatic test_basic();
        run_op(1'b0, 8'h12, 8'h34, 1'b0, 1);
        run_op(1'b1, 8'hFF, 8'h01, 1'b0, 1);
    endtask

    task automatic test_latency();
        run_op(1'b0, 8'h5A, 8'h3C, 1'b1, 3);
        run_op(1'b1, 8'h80, 8'h80, 1'b1, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            run_op(1'($urandom), DATA_W'($urandom), DATA_W'($urandom), 1'($urandom),
                   int'($urandom_range(1, 4)));
        end
        run_op(1'b0, 8'h9E, 8'h21, 1'b0, 2);   // leaves a non-zero res before the abort
    endtask

    task automatic test_timeout();
        int cyc;
        bit got;
        @(negedge clk);
        stall = 1'b1;
        a0 = 8'h33; b0 = 8'h44; cin0 = 1'b0; req0 = 1'b1;
        cyc = 1; got = 1'b0;
        while (!got && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (done0 || done1) got = 1'b1;
        end
        req0 = 1'b0;
        n_checks++;
        if (!got || cyc != 1 + TIMEOUT + 1) begin
            n_fail++;
            $display("FAIL abort_latency: got done=%0d after %0d cycles expected %0d", got, cyc, 1 + TIMEOUT + 1);
        end
        n_checks++;
        if ({done0, err, cout, add_en} !== 4'b1100 || res !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got done0/err/cout/add_en=%b res=%h expected 1100 res=00",
                     {done0, err, cout, add_en}, res);
        end
        @(negedge clk);
        stall = 1'b0;
        n_checks++;
        if ({done0, busy, err} !== 3'b001) begin
            n_fail++;
            $display("FAIL abort_after: got done0/busy/err=%b expected 001", {done0, busy, err});
        end
    endtask

    task automatic test_reset_midop();
        int cyc, hs;
        bit seen_done;
        lat = 3;
        @(negedge clk);
        a0 = 8'h0F; b0 = 8'h01; cin0 = 1'b0; req0 = 1'b1;
        cyc = 0; hs = 0;
        while (!(add_en && hs == 1) && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (add_en && add_ready) hs++;
        end
        n_checks++;
        if (cyc >= 50) begin
            n_fail++;
            $display("FAIL midreset_reach: got %0d passes after %0d cycles, required second ISSUE", hs, cyc);
        end
        reset = 1'b1; req0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({busy, add_en, done0, done1, cout, err} !== 6'b0 || res !== '0) begin
            n_fail++;
            $display("FAIL midreset_state: got busy/en/d0/d1/cout/err=%b res=%h expected 000000 res=00",
                     {busy, add_en, done0, done1, cout, err}, res);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done0 || done1 || busy) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL midreset_no_done: got activity after reset expected idle");
        end
        run_op(1'b0, 8'h0F, 8'h01, 1'b0, 1);
    endtask

    // Both requesters ask twice, holding req high until their ops complete
    task automatic test_arbitration();
        int left0, left1, cyc, p0, p1;
        int order[$], exp_order[$];
        logic [DATA_W-1:0] rres[$];
        bit pick;
`ifdef ARB_RR_EN
        bit last;
        last = 1'b1;
`endif
        p0 = 2; p1 = 2;
        while (p0 > 0 || p1 > 0) begin
            if (p0 > 0 && p1 > 0) begin
`ifdef ARB_RR_EN
                pick = !last;
`else
                pick = 1'b0;
`endif
            end else begin
                pick = (p1 > 0);
            end
            exp_order.push_back(int'(pick));
            if (pick) p1--; else p0--;
`ifdef ARB_RR_EN
            last = pick;
`endif
        end
        do_reset();
        lat = 1;
        @(negedge clk);
        a0 = 8'h01; b0 = 8'h01; cin0 = 1'b0;
        a1 = 8'h02; b1 = 8'h02; cin1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        left0 = 2; left1 = 2; cyc = 0;
        while ((left0 > 0 || left1 > 0) && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (done0) begin
                order.push_back(0); rres.push_back(res);
                left0--;
                if (left0 <= 0) req0 = 1'b0;
            end
            if (done1) begin
                order.push_back(1); rres.push_back(res);
                left1--;
                if (left1 <= 0) req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        n_checks++;
        if (order.size() != exp_order.size()) begin
            n_fail++;
            $display("FAIL arb_count: got %0d completions in %0d cycles expected %0d",
                     order.size(), cyc, exp_order.size());
        end else begin
            for (int i = 0; i < order.size(); i++) begin
                logic [DATA_W-1:0] exp_r;
                exp_r = (exp_order[i] == 1) ? DATA_W'(8'h02 + 8'h02) : DATA_W'(8'h01 + 8'h01);
                n_checks++;
                if (order[i] != exp_order[i] || rres[i] !== exp_r) begin
                    n_fail++;
                    $display("FAIL arb_slot%0d: got requester %0d res=%h expected requester %0d res=%h",
                             i, order[i], rres[i], exp_order[i], exp_r);
                end
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_random();
        test_timeout();
        test_reset_midop();
        test_arbitration();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
